// File: rtl/ram_pkg.sv
// Shared constants and FSM state encoding for the RAM burst master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ram_pkg;

  localparam int RAM_AW    = 10;
  localparam int RAM_DW    = 8;
  localparam int RAM_DEPTH = 1 << RAM_AW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/ram_rd_fifo.sv
// Small synchronous FIFO buffering read bytes returned by the RAM.
// Latency: a pushed entry is visible at head the cycle after the push.
// Backpressure: none internally; the producer guarantees it never pushes into a full FIFO.
module ram_rd_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [DW-1:0]              head,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  // A pop of an empty FIFO is ignored; a push into a full FIFO only lands when a pop frees a slot.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != (PW+1)'(DEPTH)) || do_pop);

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port synchronous RAM: streams write bytes in, read bytes out.
// Latency: write byte hits RAM pins 1 cycle after handshake; first read byte 3 cycles after command.
// Backpressure: wr_valid gaps stall writes; reads issue only while FIFO slots plus in-flight reads allow.
module ram_burst_master
  import ram_pkg::*;
#(
  parameter int AW            = RAM_AW,
  parameter int DW            = RAM_DW,
  parameter int RD_FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_data_in,
  output logic          ram_we,
  input  logic [DW-1:0] ram_data_out
);

  localparam int CW = $clog2(RD_FIFO_DEPTH) + 1;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   rem_q, rem_d;
  logic [AW-1:0] ram_address_q, ram_address_d;
  logic [DW-1:0] ram_data_in_q, ram_data_in_d;
  logic          ram_we_q, ram_we_d;
  logic          done_q, done_d;
  // bit 0: address registered this cycle; bit 1: RAM has sampled it, data arrives at next edge
  logic [1:0]    rd_pipe_q, rd_pipe_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic [DW-1:0] fifo_head;
  logic          rd_pop;
  logic [1:0]    inflight;
  logic [CW:0]   rd_credit_used;

  assign inflight       = {1'b0, rd_pipe_q[0]} + {1'b0, rd_pipe_q[1]};
  assign rd_credit_used = {1'b0, fifo_count} + {{(CW-1){1'b0}}, inflight};
  assign rd_pop         = rd_valid && rd_ready;

  ram_rd_fifo #(
    .DW    (DW),
    .DEPTH (RD_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_pipe_q[1]),
    .push_data (ram_data_out),
    .pop       (rd_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Next-state, RAM pin and handshake decode for the burst FSM.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    ram_address_d = ram_address_q;
    ram_data_in_d = ram_data_in_q;
    ram_we_d      = 1'b0;
    done_d        = 1'b0;
    rd_pipe_d     = {rd_pipe_q[0], 1'b0};
    wr_ready      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          rem_d   = {1'b0, cmd_len} + 1'b1;
          state_d = cmd_we ? WRITE : READ;
        end
      end
      WRITE: begin
        if (rem_q != '0) begin
          wr_ready = 1'b1;
          if (wr_valid) begin
            ram_we_d      = 1'b1;
            ram_address_d = addr_q;
            ram_data_in_d = wr_data;
            addr_d        = addr_q + 1'b1;
            rem_d         = rem_q - 1'b1;
          end
        end else begin
          // last ram_we is on the pins this cycle; pulse done next
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      READ: begin
        if (rem_q != '0) begin
          // credit rule keeps FIFO entries plus outstanding reads within FIFO depth
          if (rd_credit_used < (CW+1)'(RD_FIFO_DEPTH)) begin
            ram_address_d = addr_q;
            addr_d        = addr_q + 1'b1;
            rem_d         = rem_q - 1'b1;
            rd_pipe_d[0]  = 1'b1;
          end
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((rd_pipe_q == 2'b00) && fifo_empty) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered RAM-side outputs; reset aborts any burst in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      rem_q         <= '0;
      ram_address_q <= '0;
      ram_data_in_q <= '0;
      ram_we_q      <= 1'b0;
      done_q        <= 1'b0;
      rd_pipe_q     <= 2'b00;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      rem_q         <= rem_d;
      ram_address_q <= ram_address_d;
      ram_data_in_q <= ram_data_in_d;
      ram_we_q      <= ram_we_d;
      done_q        <= done_d;
      rd_pipe_q     <= rd_pipe_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign rd_valid    = !fifo_empty;
  assign rd_data     = fifo_head;
  assign ram_address = ram_address_q;
  assign ram_data_in = ram_data_in_q;
  assign ram_we      = ram_we_q;

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a behavioural synchronous 1024x8 RAM.
// Latency: n/a.
// Backpressure: rd_ready patterns driven by the scenarios.
module tb_ram_burst_master;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_we;
  logic [9:0] cmd_addr, cmd_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_ready;
  logic [7:0] rd_data;
  logic       busy, done;
  logic [9:0] ram_address;
  logic [7:0] ram_data_in;
  logic       ram_we;
  logic [7:0] ram_data_out;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int done_cnt     = 0;
  int over_cnt     = 0;

  logic [7:0] mem  [1024];
  logic [7:0] wbuf [1024];

  logic [9:0] wa_q[$];
  logic [7:0] wd_q[$];
  int         wc_q[$];
  logic [7:0] rd_q[$];
  int         rc_q[$];
  int         dc_q[$];

  ram_burst_master dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_we       (cmd_we),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .busy         (busy),
    .done         (done),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_we       (ram_we),
    .ram_data_out (ram_data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous RAM: address sampled at an edge, data on data_out after it
  always @(posedge clk) begin
    if (ram_we) mem[ram_address] <= ram_data_in;
    ram_data_out <= mem[ram_address];
  end

  // event logger, sampled mid-cycle
  always @(negedge clk) begin
    if (ram_we) begin
      wa_q.push_back(ram_address);
      wd_q.push_back(ram_data_in);
      wc_q.push_back(cyc);
    end
    if (rd_valid && rd_ready) begin
      rd_q.push_back(rd_data);
      rc_q.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      dc_q.push_back(cyc);
    end
    if (dut.rd_credit_used > 4'd4) over_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input logic we, input logic [9:0] a, input logic [9:0] len, output int c0);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = len;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    c0 = cyc;
  endtask

  task automatic write_bytes(input int n, input bit gap, output bit ok);
    bit hs;
    int guard;
    ok = 1'b1;
    for (int i = 0; i < n && ok; i++) begin
      hs = 1'b0; guard = 0;
      wr_valid = 1'b1; wr_data = wbuf[i];
      while (!hs && guard < 100) begin
        @(negedge clk); hs = wr_ready;
        @(posedge clk); #1;
        guard++;
      end
      if (!hs) ok = 1'b0;
      if (gap) begin
        wr_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1; cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_len = 0;
    wr_valid = 0; wr_data = 0; rd_ready = 0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    tests_run++; if (ram_we !== 1'b0)        begin tests_failed++; $display("FAIL rst_ram_we: got %b want 0", ram_we); end
    tests_run++; if (ram_address !== 10'h0)  begin tests_failed++; $display("FAIL rst_ram_address: got %h want 000", ram_address); end
    tests_run++; if (ram_data_in !== 8'h0)   begin tests_failed++; $display("FAIL rst_ram_data_in: got %h want 00", ram_data_in); end
    tests_run++; if (busy !== 1'b0)          begin tests_failed++; $display("FAIL rst_busy: got %b want 0", busy); end
    tests_run++; if (done !== 1'b0)          begin tests_failed++; $display("FAIL rst_done: got %b want 0", done); end
    tests_run++; if (wr_ready !== 1'b0)      begin tests_failed++; $display("FAIL rst_wr_ready: got %b want 0", wr_ready); end
    tests_run++; if (rd_valid !== 1'b0)      begin tests_failed++; $display("FAIL rst_rd_valid: got %b want 0", rd_valid); end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++; if (cmd_ready !== 1'b1)     begin tests_failed++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_burst;
    int s, d0, c0;
    bit ok1, ok2;
    s = wa_q.size(); d0 = done_cnt;
    for (int i = 0; i < 4; i++) wbuf[i] = 8'hA0 + 8'(i);
    send_cmd(1'b1, 10'h010, 10'd3, c0);
    write_bytes(4, 1'b0, ok1);
    wait_done(50, ok2);
    tests_run++; if (!(ok1 && ok2)) begin tests_failed++; $display("FAIL wr_timeout: hs_ok %b done_ok %b want 1 1", ok1, ok2); end
    tests_run++; if (wa_q.size() - s != 4) begin tests_failed++; $display("FAIL wr_we_count: got %0d want 4", wa_q.size() - s); end
    tests_run++; if (wc_q[s] != c0 + 1) begin tests_failed++; $display("FAIL wr_first_we_cycle: got %0d want %0d", wc_q[s], c0 + 1); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (wa_q[s+i] !== 10'h010 + 10'(i) || wd_q[s+i] !== 8'hA0 + 8'(i) || wc_q[s+i] != c0 + 1 + i) begin
        tests_failed++;
        $display("FAIL wr_beat%0d: got addr %h data %h cyc %0d want addr %h data %h cyc %0d",
                 i, wa_q[s+i], wd_q[s+i], wc_q[s+i], 10'h010 + 10'(i), 8'hA0 + 8'(i), c0 + 1 + i);
      end
      tests_run++;
      if (mem[10'h010 + 10'(i)] !== 8'hA0 + 8'(i)) begin
        tests_failed++; $display("FAIL wr_mem%0d: got %h want %h", i, mem[10'h010 + 10'(i)], 8'hA0 + 8'(i));
      end
    end
    tests_run++; if (done_cnt - d0 != 1) begin tests_failed++; $display("FAIL wr_done_count: got %0d want 1", done_cnt - d0); end
    tests_run++; if (dc_q[$] != c0 + 5) begin tests_failed++; $display("FAIL wr_done_cycle: got %0d want %0d", dc_q[$], c0 + 5); end
  endtask

  task automatic test_read_burst;
    int s, ws, d0, c0;
    bit ok;
    s = rd_q.size(); ws = wa_q.size(); d0 = done_cnt;
    rd_ready = 1'b1;
    send_cmd(1'b0, 10'h010, 10'd3, c0);
    wait_done(50, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL rd_timeout: done seen %b want 1", ok); end
    tests_run++; if (rd_q.size() - s != 4) begin tests_failed++; $display("FAIL rd_count: got %0d want 4", rd_q.size() - s); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (rd_q[s+i] !== 8'hA0 + 8'(i) || rc_q[s+i] != c0 + 3 + i) begin
        tests_failed++;
        $display("FAIL rd_beat%0d: got data %h cyc %0d want data %h cyc %0d",
                 i, rd_q[s+i], rc_q[s+i], 8'hA0 + 8'(i), c0 + 3 + i);
      end
    end
    tests_run++; if (wa_q.size() != ws) begin tests_failed++; $display("FAIL rd_no_we: got %0d writes want 0", wa_q.size() - ws); end
    tests_run++; if (done_cnt - d0 != 1) begin tests_failed++; $display("FAIL rd_done_count: got %0d want 1", done_cnt - d0); end
    tests_run++; if (dc_q[$] != c0 + 8) begin tests_failed++; $display("FAIL rd_done_cycle: got %0d want %0d", dc_q[$], c0 + 8); end
  endtask

  task automatic test_wrap;
    int s, rs, c0;
    bit ok1, ok2, ok3;
    logic [9:0] exp_a [4];
    exp_a[0] = 10'h3FE; exp_a[1] = 10'h3FF; exp_a[2] = 10'h000; exp_a[3] = 10'h001;
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
    s = wa_q.size(); rs = rd_q.size();
    send_cmd(1'b1, 10'h3FE, 10'd3, c0);
    write_bytes(4, 1'b0, ok1);
    wait_done(50, ok2);
    rd_ready = 1'b1;
    send_cmd(1'b0, 10'h3FE, 10'd3, c0);
    wait_done(50, ok3);
    tests_run++; if (!(ok1 && ok2 && ok3)) begin tests_failed++; $display("FAIL wrap_timeout: %b%b%b want 111", ok1, ok2, ok3); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (wa_q[s+i] !== exp_a[i] || wd_q[s+i] !== wbuf[i]) begin
        tests_failed++; $display("FAIL wrap_wr%0d: got addr %h data %h want addr %h data %h", i, wa_q[s+i], wd_q[s+i], exp_a[i], wbuf[i]);
      end
      tests_run++;
      if (rd_q[rs+i] !== wbuf[i]) begin
        tests_failed++; $display("FAIL wrap_rd%0d: got %h want %h", i, rd_q[rs+i], wbuf[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int rs, d0, o0, c0, k;
    bit ok1, ok2, seen;
    logic [3:0] pat;
    pat = 4'b1001;
    for (int i = 0; i < 8; i++) wbuf[i] = 8'hC0 + 8'(i);
    d0 = done_cnt;
    send_cmd(1'b1, 10'h120, 10'd7, c0);
    write_bytes(8, 1'b1, ok1);
    wait_done(50, ok2);
    rs = rd_q.size(); o0 = over_cnt;
    send_cmd(1'b0, 10'h120, 10'd7, c0);
    seen = 1'b0; k = 0;
    while (!seen && k < 300) begin
      rd_ready = pat[k % 4];
      @(negedge clk); if (done) seen = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    rd_ready = 1'b1;
    tests_run++; if (!(ok1 && ok2 && seen)) begin tests_failed++; $display("FAIL bp_timeout: %b%b%b want 111", ok1, ok2, seen); end
    tests_run++; if (rd_q.size() - rs != 8) begin tests_failed++; $display("FAIL bp_count: got %0d want 8", rd_q.size() - rs); end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (rd_q[rs+i] !== 8'hC0 + 8'(i)) begin tests_failed++; $display("FAIL bp_rd%0d: got %h want %h", i, rd_q[rs+i], 8'hC0 + 8'(i)); end
    end
    tests_run++; if (over_cnt != o0) begin tests_failed++; $display("FAIL bp_credit: got %0d cycles over 4 want 0", over_cnt - o0); end
    tests_run++; if (done_cnt - d0 != 2) begin tests_failed++; $display("FAIL bp_done_count: got %0d want 2", done_cnt - d0); end
  endtask

  task automatic test_full_burst;
    int s, rs, d0, c0, bad;
    bit ok1, ok2, ok3;
    logic [9:0] a;
    for (int i = 0; i < 1024; i++) begin
      a = 10'h2A5 + 10'(i);
      wbuf[i] = a[7:0] ^ 8'h5A;
    end
    s = wa_q.size(); d0 = done_cnt;
    send_cmd(1'b1, 10'h2A5, 10'd1023, c0);
    write_bytes(1024, 1'b0, ok1);
    wait_done(50, ok2);
    tests_run++; if (wa_q.size() - s != 1024) begin tests_failed++; $display("FAIL full_we_count: got %0d want 1024", wa_q.size() - s); end
    tests_run++; if (wa_q[$] !== 10'h2A4) begin tests_failed++; $display("FAIL full_last_addr: got %h want 2a4", wa_q[$]); end
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      a = 10'(i);
      if (mem[a] !== (a[7:0] ^ 8'h5A)) bad++;
    end
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL full_mem: got %0d bad bytes want 0", bad); end
    rs = rd_q.size(); rd_ready = 1'b1;
    send_cmd(1'b0, 10'h2A5, 10'd1023, c0);
    wait_done(1200, ok3);
    tests_run++; if (!(ok1 && ok2 && ok3)) begin tests_failed++; $display("FAIL full_timeout: %b%b%b want 111", ok1, ok2, ok3); end
    tests_run++; if (rd_q.size() - rs != 1024) begin tests_failed++; $display("FAIL full_rd_count: got %0d want 1024", rd_q.size() - rs); end
    bad = 0;
    for (int i = 0; i < 1024; i++) if (rd_q[rs+i] !== wbuf[i]) bad++;
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL full_rd_data: got %0d bad bytes want 0", bad); end
    tests_run++; if (rc_q[rs+1023] - rc_q[rs] != 1023) begin tests_failed++; $display("FAIL full_rd_rate: got span %0d want 1023", rc_q[rs+1023] - rc_q[rs]); end
    tests_run++; if (done_cnt - d0 != 2) begin tests_failed++; $display("FAIL full_done_count: got %0d want 2", done_cnt - d0); end
  endtask

  task automatic test_reset_mid_write;
    int s, rs, c0;
    bit ok1, ok2, ok3;
    for (int i = 0; i < 8; i++) wbuf[i] = 8'hE0 + 8'(i);
    s = wa_q.size();
    send_cmd(1'b1, 10'h050, 10'd7, c0);
    write_bytes(2, 1'b0, ok1);
    @(posedge clk); #3;
    rst_n = 1'b0; wr_valid = 1'b1; wr_data = 8'hEE;
    #1;
    tests_run++; if (ram_we !== 1'b0 || ram_address !== 10'h0 || ram_data_in !== 8'h0) begin
      tests_failed++; $display("FAIL mid_rst_ram: got we %b addr %h din %h want 0 000 00", ram_we, ram_address, ram_data_in);
    end
    tests_run++; if (busy !== 1'b0 || done !== 1'b0 || wr_ready !== 1'b0 || rd_valid !== 1'b0) begin
      tests_failed++; $display("FAIL mid_rst_ctl: got busy %b done %b wr_ready %b rd_valid %b want 0000", busy, done, wr_ready, rd_valid);
    end
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    wr_valid = 1'b0;
    tests_run++; if (wa_q.size() - s != 2) begin tests_failed++; $display("FAIL mid_rst_we_count: got %0d want 2", wa_q.size() - s); end
    tests_run++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL mid_rst_idle: got busy %b cmd_ready %b want 0 1", busy, cmd_ready); end
    wbuf[0] = 8'hD1; wbuf[1] = 8'hD2;
    send_cmd(1'b1, 10'h060, 10'd1, c0);
    write_bytes(2, 1'b0, ok2);
    wait_done(50, ok3);
    rs = rd_q.size(); rd_ready = 1'b1;
    send_cmd(1'b0, 10'h060, 10'd1, c0);
    wait_done(50, ok1);
    tests_run++; if (!(ok1 && ok2 && ok3)) begin tests_failed++; $display("FAIL post_rst_timeout: %b%b%b want 111", ok1, ok2, ok3); end
    tests_run++; if (rd_q[rs] !== 8'hD1 || rd_q[rs+1] !== 8'hD2) begin
      tests_failed++; $display("FAIL post_rst_rd: got %h %h want d1 d2", rd_q[rs], rd_q[rs+1]);
    end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_burst();
    test_wrap();
    test_backpressure();
    test_full_burst();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
